// File: rtl/core_inst_seq_if.sv
// Instruction-sequencer handshake bundle: host start/kij, core ofifo_valid,
// and the registered inst/busy/done outputs.
interface core_inst_seq_if;
    logic        start;
    logic [3:0]  kij;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;

    modport master (
        input  start, kij, ofifo_valid,
        output inst, busy, done
    );

    modport slave (
        output start, kij, ofifo_valid,
        input  inst, busy, done
    );
endinterface

// File: rtl/core_inst_seq.sv
// Generates the 34-bit core instruction stream for one kij pass:
// weight fetch, weight load, gap, activation fetch, execute, OFIFO drain.
module core_inst_seq #(
    parameter int unsigned col     = 8,
    parameter int unsigned row     = 8,
    parameter int unsigned len_nij = 36,
    parameter int unsigned len_kij = 9,
    parameter int unsigned gap_cyc = 10,
    parameter logic [10:0] wbase   = 11'h400
) (
    input  logic           clk,
    input  logic           reset,
    core_inst_seq_if.master bus
);

    localparam logic [33:0] IDLE_WORD   = 34'h1800C0000;
    localparam logic [15:0] W_RD_LAST   = 16'(2 * col);
    localparam logic [15:0] W_LOAD_LAST = 16'(row + col - 1);
    localparam logic [15:0] W_HOLD_LAST = 16'(col - 1);
    localparam logic [15:0] GAP_LAST    = 16'(gap_cyc - 1);
    localparam logic [15:0] A_L0_LAST   = 16'(2 * len_nij);
    localparam logic [15:0] EXEC_LAST   = 16'(2 * len_nij + row + col - 1);
    localparam logic [15:0] NIJ         = 16'(len_nij);
    localparam logic [10:0] NIJ11       = 11'(len_nij);
    localparam logic [3:0]  KIJ_LIM     = 4'(len_kij);

    typedef enum logic [2:0] {
        IDLE, W_RD, W_LOAD, W_HOLD, GAP, A_L0, EXEC, DRAIN
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] t, t_nxt;
    logic [15:0] n, n_nxt;
    logic [3:0]  kij_q, kij_nxt;
    logic [33:0] inst_q, inst_nxt;
    logic        busy_q, done_q, done_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            t      <= '0;
            n      <= '0;
            kij_q  <= '0;
            inst_q <= IDLE_WORD;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            t      <= t_nxt;
            n      <= n_nxt;
            kij_q  <= kij_nxt;
            inst_q <= inst_nxt;
            busy_q <= (state_nxt != IDLE);
            done_q <= done_nxt;
        end
    end

    // The word is built from the next state/counter so the registered inst
    // always matches the state register it is issued alongside.
    always_comb begin
        state_nxt = state;
        t_nxt     = t + 16'd1;
        n_nxt     = n;
        kij_nxt   = kij_q;
        done_nxt  = 1'b0;
        inst_nxt  = IDLE_WORD;

        unique case (state)
            IDLE: begin
                t_nxt = '0;
                if (bus.start && (bus.kij < KIJ_LIM)) begin
                    state_nxt = W_RD;
                    kij_nxt   = bus.kij;
                end
            end
            W_RD:   if (t == W_RD_LAST)   begin state_nxt = W_LOAD; t_nxt = '0; end
            W_LOAD: if (t == W_LOAD_LAST) begin state_nxt = W_HOLD; t_nxt = '0; end
            W_HOLD: if (t == W_HOLD_LAST) begin state_nxt = GAP;    t_nxt = '0; end
            GAP:    if (t == GAP_LAST)    begin state_nxt = A_L0;   t_nxt = '0; end
            A_L0:   if (t == A_L0_LAST)   begin state_nxt = EXEC;   t_nxt = '0; end
            EXEC: begin
                if (t == EXEC_LAST) begin
                    state_nxt = DRAIN;
                    t_nxt     = '0;
                    n_nxt     = '0;
                end
            end
            DRAIN: begin
                t_nxt = '0;
                if (n == NIJ) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        unique case (state_nxt)
            W_RD: begin
                inst_nxt[19]   = 1'b0;
                inst_nxt[17:7] = wbase + t_nxt[10:0];
                inst_nxt[5]    = 1'b1;
            end
            W_LOAD: begin
                inst_nxt[4] = 1'b1;
                inst_nxt[0] = 1'b1;
            end
            W_HOLD: inst_nxt[0] = 1'b1;
            A_L0: begin
                inst_nxt[19]   = 1'b0;
                inst_nxt[17:7] = t_nxt[10:0];
                inst_nxt[2]    = 1'b1;
            end
            EXEC: begin
                inst_nxt[3] = 1'b1;
                inst_nxt[1] = 1'b1;
            end
            DRAIN: begin
                if (bus.ofifo_valid) begin
                    inst_nxt[32]    = 1'b0;
                    inst_nxt[31]    = 1'b0;
                    inst_nxt[30:20] = NIJ11 * {7'd0, kij_nxt} + n_nxt[10:0];
                    inst_nxt[6]     = 1'b1;
                    n_nxt           = n_nxt + 16'd1;
                end
            end
            default: inst_nxt = IDLE_WORD;
        endcase
    end

    assign bus.inst = inst_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed bench for core_inst_seq: per-cycle instruction schedule checks,
// drain stall/alternation, ignored starts, out-of-range kij and mid-pass reset.
module tb_core_inst_seq;

    localparam logic [33:0] IDLE_W = 34'h1800C0000;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    core_inst_seq_if bus ();

    core_inst_seq #(
        .col(8), .row(8), .len_nij(36), .len_kij(9), .gap_cyc(10), .wbase(11'h400)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Hand-derived schedule for busy cycle c (1-based) before the drain starts at c=213.
    function automatic logic [33:0] sched_word(input int c);
        logic [10:0] a;
        if (c <= 17) begin
            a = 11'h400 + 11'(c - 1);
            return 34'h180040020 | (34'(a) << 7);
        end else if (c <= 33) return 34'h1800C0011;
        else if (c <= 41) return 34'h1800C0001;
        else if (c <= 51) return IDLE_W;
        else if (c <= 124) begin
            a = 11'(c - 52);
            return 34'h180040004 | (34'(a) << 7);
        end
        return 34'h1800C000A;
    endfunction

    // vmode 0: ofifo_valid tied high; vmode 1: low for 5 drain cycles then alternating.
    task automatic run_pass(input logic [3:0] k, input int vmode, input int mid_at);
        int c, wr_model, obs_wr, dones, exp_busy;
        logic vprev;
        logic [33:0] exp;
        logic [10:0] a;
        bus.kij         = k;
        bus.start       = 1'b1;
        bus.ofifo_valid = (vmode == 0);
        vprev           = bus.ofifo_valid;
        tick();
        bus.start = 1'b0;
        bus.kij   = 4'd5;
        c = 1; wr_model = 0; obs_wr = 0; dones = 0;
        while (bus.busy === 1'b1 && c < 400) begin
            if (c <= 212) exp = sched_word(c);
            else if (vprev && wr_model < 36) begin
                a   = 11'(36 * int'(k) + wr_model);
                exp = 34'h0000C0040 | (34'(a) << 20);
                wr_model++;
            end else exp = IDLE_W;
            check($sformatf("inst k=%0d c=%0d", k, c), bus.inst, exp);
            check("rd_gate", 34'(bus.inst[6] & ~vprev), 34'd0);
            if (bus.inst[6] === 1'b1) obs_wr++;
            if (bus.done === 1'b1) dones++;
            bus.start = (c == mid_at);
            if (c == mid_at) bus.kij = 4'd1;
            if (vmode == 1) bus.ofifo_valid = (c < 217) ? 1'b0 : ((c - 217) % 2 == 0);
            vprev = bus.ofifo_valid;
            tick();
            c++;
        end
        exp_busy = (vmode == 1) ? 288 : 248;
        check("busy_len", 34'(c - 1), 34'(exp_busy));
        check("pmem_writes", 34'(obs_wr), 34'd36);
        check("done_in_pass", 34'(dones), 34'd0);
        check("done_end", 34'(bus.done), 34'd1);
        check("idle_end", bus.inst, IDLE_W);
        bus.start = 1'b0;
        tick();
        check("done_pulse", 34'(bus.done), 34'd0);
        check("busy_after", 34'(bus.busy), 34'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.start       = 1'b0;
        bus.kij         = 4'd0;
        bus.ofifo_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_inst", bus.inst, IDLE_W);
        check("rst_busy", 34'(bus.busy), 34'd0);
        check("rst_done", 34'(bus.done), 34'd0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_inst", bus.inst, IDLE_W);
            check("idle_busy", 34'(bus.busy), 34'd0);
            check("idle_done", 34'(bus.done), 34'd0);
        end

        run_pass(4'd0, 0, -1);
        run_pass(4'd8, 0, 100);

        for (int i = 0; i < 2; i++) begin
            bus.kij   = (i == 0) ? 4'd9 : 4'd15;
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            for (int j = 0; j < 5; j++) begin
                check("oor_inst", bus.inst, IDLE_W);
                check("oor_busy", 34'(bus.busy), 34'd0);
                check("oor_done", 34'(bus.done), 34'd0);
                tick();
            end
        end

        run_pass(4'd2, 1, -1);

        bus.kij         = 4'd0;
        bus.ofifo_valid = 1'b1;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 165; c++) tick();
        check("pre_rst_exec", bus.inst, 34'h1800C000A);
        #2 reset = 1'b0;
        #1;
        check("async_rst_inst", bus.inst, IDLE_W);
        check("async_rst_busy", 34'(bus.busy), 34'd0);
        tick();
        check("rst_hold_inst", bus.inst, IDLE_W);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_inst", bus.inst, IDLE_W);
            check("post_rst_busy", 34'(bus.busy), 34'd0);
        end

        run_pass(4'd3, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
